// File: rtl/onehot_grant_dispatcher.sv
//==============================================================================
// Module      : onehot_grant_dispatcher
// Description : Turns an encoded channel index into a registered one-hot grant
//               held until ack or timeout, one grant outstanding at a time.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module onehot_grant_dispatcher #(
    parameter int N_CH    = 16,
    parameter int IDX_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             idx_valid_i,
    output logic             idx_ready_o,
    input  logic [N_CH-1:0]  ack_i,
    output logic [N_CH-1:0]  grant_o,
    output logic             busy_o,
    output logic             timeout_o,
    output logic             stray_ack_o,
    output logic [7:0]       done_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] c_hold_last = 8'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [N_CH-1:0]   r_grant;
    logic [N_CH-1:0]   w_grant_nxt;
    logic [7:0]        r_hold;
    logic [7:0]        w_hold_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_timeout;
    logic              w_timeout_nxt;
    logic              r_stray;
    logic              w_stray_nxt;
    logic [7:0]        r_done_cnt;
    logic [7:0]        w_done_nxt;

    logic [N_CH-1:0]   w_dec;
    logic [N_CH-1:0]   w_lat_mask;
    logic              w_other_ack;

    assign w_dec       = {{(N_CH-1){1'b0}}, 1'b1} << idx_i;
    assign w_lat_mask  = {{(N_CH-1){1'b0}}, 1'b1} << r_idx;
    // Acks on any channel except the latched one; the latched channel is
    // excused in GRANT (real ack) and for one trailing cycle in RELEASE.
    assign w_other_ack = |(ack_i & ~w_lat_mask);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_grant    <= '0;
            r_hold     <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_stray    <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_grant    <= w_grant_nxt;
            r_hold     <= w_hold_nxt;
            r_busy     <= w_busy_nxt;
            r_timeout  <= w_timeout_nxt;
            r_stray    <= w_stray_nxt;
            r_done_cnt <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_grant_nxt   = r_grant;
        w_hold_nxt    = r_hold;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        w_stray_nxt   = r_stray;
        w_done_nxt    = r_done_cnt;

        case (r_state)
            S_IDLE: begin
                if (|ack_i) begin
                    w_stray_nxt = 1'b1;
                end
                if (idx_valid_i) begin
                    w_idx_nxt   = idx_i;
                    w_grant_nxt = w_dec;
                    w_hold_nxt  = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_other_ack) begin
                    w_stray_nxt = 1'b1;
                end
                w_hold_nxt = r_hold + 8'd1;
                // Ack takes precedence over a timeout on the same edge.
                if (ack_i[r_idx]) begin
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = r_done_cnt + 8'd1;
                    w_state_nxt = S_RELEASE;
                end else if (r_hold == c_hold_last) begin
                    w_grant_nxt   = '0;
                    w_busy_nxt    = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (w_other_ack) begin
                    w_stray_nxt = 1'b1;
                end
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign idx_ready_o = (r_state == S_IDLE) && !rst_i;
    assign grant_o     = r_grant;
    assign busy_o      = r_busy;
    assign timeout_o   = r_timeout;
    assign stray_ack_o = r_stray;
    assign done_cnt_o  = r_done_cnt;

endmodule

`default_nettype wire

// File: tb/tb_onehot_grant_dispatcher.sv
//==============================================================================
// Module      : tb_onehot_grant_dispatcher
// Description : Directed vector table plus hand sequences for the dispatcher.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_onehot_grant_dispatcher;

    logic        clk;
    logic        rst;
    logic [3:0]  idx;
    logic        vld;
    logic        rdy;
    logic [15:0] ack;
    logic [15:0] grant;
    logic        busy;
    logic        tmo;
    logic        stray;
    logic [7:0]  done;

    int checks = 0;
    int errors = 0;

    onehot_grant_dispatcher #(
        .N_CH   (16),
        .IDX_W  (4),
        .TIMEOUT(8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .idx_i      (idx),
        .idx_valid_i(vld),
        .idx_ready_o(rdy),
        .ack_i      (ack),
        .grant_o    (grant),
        .busy_o     (busy),
        .timeout_o  (tmo),
        .stray_ack_o(stray),
        .done_cnt_o (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic        vld;
        logic [15:0] ack;
        logic [15:0] grant;
        logic        rdy;
        logic        busy;
        logic        tmo;
        logic        stray;
        logic [7:0]  done;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // idx, vld, ack  ->  grant, rdy, busy, tmo, stray, done
        vecs[0]  = '{4'h0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{4'h0, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[2]  = '{4'h0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[3]  = '{4'h4, 1'b1, 16'h0000, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[4]  = '{4'h8, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[5]  = '{4'h8, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[6]  = '{4'h8, 1'b1, 16'h0000, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        vecs[7]  = '{4'hF, 1'b1, 16'h0000, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        vecs[8]  = '{4'hF, 1'b1, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
        // Granted channel keeps ack high into RELEASE: not stray
        vecs[9]  = '{4'hF, 1'b1, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3};
        vecs[10] = '{4'hF, 1'b1, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
        vecs[11] = '{4'h0, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};
        vecs[12] = '{4'h0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4};
        vecs[13] = '{4'h2, 1'b1, 16'h0000, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4};
        vecs[14] = '{4'h2, 1'b0, 16'h0020, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b1, 8'd4};
        vecs[15] = '{4'h2, 1'b0, 16'h0000, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b1, 8'd4};
        vecs[16] = '{4'h2, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5};
        vecs[17] = '{4'h2, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5};

        rst = 1'b1;
        idx = 4'h0;
        vld = 1'b0;
        ack = 16'h0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst.grant", 32'(grant), 32'h0);
        chk("rst.rdy",   32'(rdy),   32'h1);
        chk("rst.busy",  32'(busy),  32'h0);
        chk("rst.tmo",   32'(tmo),   32'h0);
        chk("rst.stray", 32'(stray), 32'h0);
        chk("rst.done",  32'(done),  32'h0);

        for (int i = 0; i < 18; i++) begin
            idx = vecs[i].idx;
            vld = vecs[i].vld;
            ack = vecs[i].ack;
            step();
            chk($sformatf("v%0d.grant", i), 32'(grant), 32'(vecs[i].grant));
            chk($sformatf("v%0d.rdy", i),   32'(rdy),   32'(vecs[i].rdy));
            chk($sformatf("v%0d.busy", i),  32'(busy),  32'(vecs[i].busy));
            chk($sformatf("v%0d.tmo", i),   32'(tmo),   32'(vecs[i].tmo));
            chk($sformatf("v%0d.stray", i), 32'(stray), 32'(vecs[i].stray));
            chk($sformatf("v%0d.done", i),  32'(done),  32'(vecs[i].done));
        end
        vld = 1'b0;
        ack = 16'h0;

        // Timeout: never ack, grant lasts exactly 8 cycles
        begin
            int hi;
            idx = 4'h3;
            vld = 1'b1;
            step();
            vld = 1'b0;
            hi = (grant == 16'h0008) ? 1 : 0;
            for (int k = 0; k < 20; k++) begin
                if (grant != 16'h0008) break;
                step();
                if (grant == 16'h0008) hi++;
            end
            chk("to.cycles", 32'(hi),    32'd8);
            chk("to.grant",  32'(grant), 32'h0);
            chk("to.pulse",  32'(tmo),   32'h1);
            chk("to.done",   32'(done),  32'd5);
            step();
            chk("to.pulse_end", 32'(tmo), 32'h0);
            chk("to.rdy",       32'(rdy), 32'h1);
        end

        // Ack exactly on the timeout edge: ack wins
        idx = 4'h5;
        vld = 1'b1;
        step();
        vld = 1'b0;
        for (int k = 0; k < 7; k++) step();
        chk("ackto.grant_pre", 32'(grant), 32'h0020);
        ack = 16'h0020;
        step();
        ack = 16'h0;
        chk("ackto.grant", 32'(grant), 32'h0);
        chk("ackto.tmo",   32'(tmo),   32'h0);
        chk("ackto.done",  32'(done),  32'd6);
        step();
        chk("ackto.rdy",   32'(rdy),   32'h1);

        // Asynchronous reset in the middle of a grant
        idx = 4'h1;
        vld = 1'b1;
        step();
        vld = 1'b0;
        chk("ar.grant_pre", 32'(grant), 32'h0002);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.grant", 32'(grant), 32'h0);
        chk("ar.busy",  32'(busy),  32'h0);
        chk("ar.done",  32'(done),  32'h0);
        chk("ar.stray", 32'(stray), 32'h0);
        #2;
        rst = 1'b0;
        step();
        chk("ar.rdy", 32'(rdy), 32'h1);
        idx = 4'h6;
        vld = 1'b1;
        step();
        vld = 1'b0;
        chk("ar.fresh_grant", 32'(grant), 32'h0040);
        ack = 16'h0040;
        step();
        ack = 16'h0;
        chk("ar.fresh_done", 32'(done), 32'd1);
        step();

        // 255 further acked grants: count wraps 255 -> 0
        for (int n = 0; n < 255; n++) begin
            logic [3:0]  ci;
            logic [15:0] oh;
            ci = 4'(n % 16);
            oh = 16'h0001 << ci;
            idx = ci;
            vld = 1'b1;
            step();
            vld = 1'b0;
            chk($sformatf("wrap%0d.grant", n), 32'(grant), 32'(oh));
            ack = oh;
            step();
            ack = 16'h0;
            if (n == 253) chk("wrap.done255_pre", 32'(done), 32'd255);
            step();
        end
        chk("wrap.done", 32'(done),  32'd0);
        chk("wrap.stray", 32'(stray), 32'h0);
        chk("wrap.rdy",  32'(rdy),   32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
